// File: rtl/jam_cost_server.sv
// jam_cost_server: loads an NxN cost table from a beat stream, serves JAM cost lookups and a row-min lower bound
module jam_cost_server #(
    parameter int CW  = 7,
    parameter int N   = 8,
    parameter int LBW = 10,
    parameter int AW  = $clog2(N)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CLR,
    input  logic            LD_VALID,
    input  logic [CW-1:0]   LD_DATA,
    output logic            LD_READY,
    input  logic [AW-1:0]   W,
    input  logic [AW-1:0]   J,
    output logic [CW-1:0]   Cost,
    output logic            TBL_READY,
    output logic [2*AW:0]   LD_CNT,
    output logic [LBW-1:0]  LOWER_BOUND
);
    localparam int CNTW = 2 * AW + 1;
    localparam int KW   = 2 * AW;

    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [LBW-1:0]  lb_q, lb_d;
    logic [CW-1:0]   runmin_q, runmin_d;
    logic [CW-1:0]   mem_q [N*N];
    logic [KW-1:0]   k;
    logic [CW-1:0]   rmin;
    logic            accept;
    logic            row_end;
    logic            wr_en;

    assign k           = cnt_q[KW-1:0];
    assign LD_READY    = !RST && (state_q != READY);
    assign accept      = LD_VALID && LD_READY;
    assign TBL_READY   = (state_q == READY);
    assign LD_CNT      = cnt_q;
    assign LOWER_BOUND = lb_q;

    // Table read is only visible once every entry has been loaded
    always_comb begin
        Cost = TBL_READY ? mem_q[{W, J}] : '0;
    end

    // Next-state: clear wins over a simultaneous beat; last beat of each row folds its minimum into the bound
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lb_d     = lb_q;
        runmin_d = runmin_q;
        wr_en    = 1'b0;
        rmin     = (LD_DATA < runmin_q) ? LD_DATA : runmin_q;
        row_end  = &k[AW-1:0];
        if (CLR) begin
            state_d  = EMPTY;
            cnt_d    = '0;
            lb_d     = '0;
            runmin_d = '1;
        end else if (accept) begin
            wr_en    = 1'b1;
            cnt_d    = cnt_q + CNTW'(1);
            lb_d     = row_end ? lb_q + LBW'(rmin) : lb_q;
            runmin_d = row_end ? '1 : rmin;
            state_d  = (k == KW'(N * N - 1)) ? READY : LOAD;
        end
    end

    // Control and accumulator registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= EMPTY;
            cnt_q    <= '0;
            lb_q     <= '0;
            runmin_q <= '1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lb_q     <= lb_d;
            runmin_q <= runmin_d;
        end
    end

    // Single write port into the cost array; contents survive reset and clear
    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[k] <= LD_DATA;
    end
endmodule

// File: tb/tb_jam_cost_server.sv
// tb_jam_cost_server: randomized self-checking bench for jam_cost_server against a table-level model
module tb_jam_cost_server;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CLR = 1'b0;
    logic       LD_VALID = 1'b0;
    logic [6:0] LD_DATA = '0;
    logic       LD_READY;
    logic [2:0] W = '0;
    logic [2:0] J = '0;
    logic [6:0] Cost;
    logic       TBL_READY;
    logic [6:0] LD_CNT;
    logic [9:0] LOWER_BOUND;

    int checks = 0;
    int errors = 0;
    int vals[64];

    jam_cost_server dut (
        .CLK(CLK), .RST(RST), .CLR(CLR),
        .LD_VALID(LD_VALID), .LD_DATA(LD_DATA), .LD_READY(LD_READY),
        .W(W), .J(J), .Cost(Cost),
        .TBL_READY(TBL_READY), .LD_CNT(LD_CNT), .LOWER_BOUND(LOWER_BOUND)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Sum of row minima over the first `rows` rows of the model table
    function automatic int exp_lb(input int rows);
        int s = 0;
        for (int r = 0; r < rows; r++) begin
            int m = 127;
            for (int c = 0; c < 8; c++) if (vals[r*8+c] < m) m = vals[r*8+c];
            s += m;
        end
        return s;
    endfunction

    // Optimal assignment cost by DP over sets of taken jobs
    function automatic int min_assign();
        int dp[256];
        for (int m = 0; m < 256; m++) dp[m] = 1 << 30;
        dp[0] = 0;
        for (int m = 0; m < 256; m++) begin
            int w = $countones(m);
            if (w < 8 && dp[m] < (1 << 30))
                for (int j = 0; j < 8; j++)
                    if (((m >> j) & 1) == 0 && dp[m] + vals[w*8+j] < dp[m | (1 << j)])
                        dp[m | (1 << j)] = dp[m] + vals[w*8+j];
        end
        return dp[255];
    endfunction

    task automatic load_beats(input int first, input int n, input bit gaps);
        int idx = first;
        int cyc = 0;
        bit on = 1'b0;
        while (idx < first + n && cyc < 4 * n + 10) begin
            on = gaps ? ~on : 1'b1;
            LD_VALID = on;
            LD_DATA = on ? 7'(vals[idx]) : 7'($urandom_range(0, 127));
            if (on) begin
                checks++;
                if (LD_READY !== 1'b1) begin
                    errors++;
                    $display("FAIL ld_ready beat %0d got %b exp 1", idx, LD_READY);
                end
            end
            tick();
            cyc++;
            if (on) begin
                idx++;
                checks++;
                if (LD_CNT !== 7'(idx)) begin
                    errors++;
                    $display("FAIL ld_cnt got %0d exp %0d", LD_CNT, idx);
                end
                checks++;
                if (TBL_READY !== (idx == 64)) begin
                    errors++;
                    $display("FAIL tbl_ready after beat %0d got %b exp %b", idx, TBL_READY, idx == 64);
                end
                if (idx % 8 == 0) begin
                    checks++;
                    if (LOWER_BOUND !== 10'(exp_lb(idx / 8))) begin
                        errors++;
                        $display("FAIL lower_bound rows %0d got %0d exp %0d", idx / 8, LOWER_BOUND, exp_lb(idx / 8));
                    end
                end
            end
        end
        LD_VALID = 1'b0;
        checks++;
        if (idx < first + n) begin
            errors++;
            $display("FAIL load_timeout got %0d beats exp %0d", idx - first, n);
        end
    endtask

    task automatic sweep(input bit ready);
        for (int i = 0; i < 64; i++) begin
            logic [5:0] a;
            a = 6'(i);
            W = a[5:3];
            J = a[2:0];
            #1;
            checks++;
            if (Cost !== (ready ? 7'(vals[i]) : 7'd0)) begin
                errors++;
                $display("FAIL cost_sweep addr %0d got %0d exp %0d", i, Cost, ready ? vals[i] : 0);
            end
        end
    endtask

    task automatic do_clear();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        checks++;
        if (LD_CNT !== 7'd0 || LOWER_BOUND !== 10'd0 || TBL_READY !== 1'b0 || LD_READY !== 1'b1) begin
            errors++;
            $display("FAIL clear_state got cnt %0d lb %0d rdy %b ldr %b exp 0 0 0 1", LD_CNT, LOWER_BOUND, TBL_READY, LD_READY);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        checks++;
        if (LD_READY !== 1'b0) begin
            errors++;
            $display("FAIL reset_ld_ready got %b exp 0", LD_READY);
        end
        checks++;
        if (LD_CNT !== 7'd0 || LOWER_BOUND !== 10'd0 || TBL_READY !== 1'b0 || Cost !== 7'd0) begin
            errors++;
            $display("FAIL reset_state got cnt %0d lb %0d rdy %b cost %0d exp 0 0 0 0", LD_CNT, LOWER_BOUND, TBL_READY, Cost);
        end
        RST = 1'b0;
        tick();
        checks++;
        if (LD_READY !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ld_ready got %b exp 1", LD_READY);
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 64; i++) vals[i] = i % 128;
        load_beats(0, 64, 1'b0);
        W = 3'd5;
        J = 3'd3;
        #1;
        checks++;
        if (LOWER_BOUND !== 10'd224) begin
            errors++;
            $display("FAIL ramp_lb got %0d exp 224", LOWER_BOUND);
        end
        checks++;
        if (Cost !== 7'd43) begin
            errors++;
            $display("FAIL ramp_cost53 got %0d exp 43", Cost);
        end
    endtask

    task automatic test_gaps();
        do_clear();
        for (int i = 0; i < 64; i++) vals[i] = 100;
        vals[18] = 7;
        load_beats(0, 64, 1'b1);
        W = 3'd2;
        J = 3'd2;
        #1;
        checks++;
        if (LOWER_BOUND !== 10'd707) begin
            errors++;
            $display("FAIL gaps_lb got %0d exp 707", LOWER_BOUND);
        end
        checks++;
        if (Cost !== 7'd7) begin
            errors++;
            $display("FAIL gaps_cost22 got %0d exp 7", Cost);
        end
    endtask

    task automatic test_sweep_and_ready_ignore();
        do_clear();
        for (int i = 0; i < 64; i++) vals[i] = int'($urandom_range(0, 127));
        load_beats(0, 20, 1'b1);
        sweep(1'b0);
        load_beats(20, 44, 1'b0);
        sweep(1'b1);
        LD_VALID = 1'b1;
        LD_DATA = 7'd99;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (LD_READY !== 1'b0) begin
                errors++;
                $display("FAIL ready_ld_ready got %b exp 0", LD_READY);
            end
            tick();
            checks++;
            if (LD_CNT !== 7'd64 || TBL_READY !== 1'b1) begin
                errors++;
                $display("FAIL ready_hold got cnt %0d rdy %b exp 64 1", LD_CNT, TBL_READY);
            end
        end
        LD_VALID = 1'b0;
        sweep(1'b1);
    endtask

    task automatic test_clear_midload();
        do_clear();
        for (int i = 0; i < 64; i++) vals[i] = 0;
        load_beats(0, 30, 1'b0);
        for (int i = 0; i < 64; i++) vals[i] = 1;
        LD_VALID = 1'b1;
        LD_DATA = 7'd1;
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        LD_VALID = 1'b0;
        checks++;
        if (LD_CNT !== 7'd0 || LOWER_BOUND !== 10'd0 || TBL_READY !== 1'b0 || LD_READY !== 1'b1) begin
            errors++;
            $display("FAIL clr_beat got cnt %0d lb %0d rdy %b ldr %b exp 0 0 0 1", LD_CNT, LOWER_BOUND, TBL_READY, LD_READY);
        end
        load_beats(0, 64, 1'b0);
        checks++;
        if (LOWER_BOUND !== 10'd8) begin
            errors++;
            $display("FAIL clr_reload_lb got %0d exp 8", LOWER_BOUND);
        end
    endtask

    task automatic test_rst_midload();
        do_clear();
        for (int i = 0; i < 64; i++) vals[i] = 0;
        load_beats(0, 43, 1'b0);
        LD_VALID = 1'b1;
        LD_DATA = 7'd0;
        RST = 1'b1;
        CLR = 1'b1;
        tick();
        RST = 1'b0;
        CLR = 1'b0;
        LD_VALID = 1'b0;
        checks++;
        if (LD_CNT !== 7'd0 || LOWER_BOUND !== 10'd0 || TBL_READY !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got cnt %0d lb %0d rdy %b exp 0 0 0", LD_CNT, LOWER_BOUND, TBL_READY);
        end
        tick();
        for (int i = 0; i < 64; i++) vals[i] = 127;
        load_beats(0, 64, 1'b0);
        checks++;
        if (LOWER_BOUND !== 10'd1016) begin
            errors++;
            $display("FAIL rst_reload_lb got %0d exp 1016", LOWER_BOUND);
        end
    endtask

    task automatic test_jam_bound();
        for (int t = 0; t < 3; t++) begin
            int mc;
            do_clear();
            for (int i = 0; i < 64; i++) vals[i] = int'($urandom_range(0, 127));
            load_beats(0, 64, t[0]);
            mc = min_assign();
            checks++;
            if (int'(LOWER_BOUND) > mc) begin
                errors++;
                $display("FAIL jam_bound got lb %0d exp <= mincost %0d", LOWER_BOUND, mc);
            end
            sweep(1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gaps();
        test_sweep_and_ready_ignore();
        test_clear_midload();
        test_rst_midload();
        test_jam_bound();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
